level_debouncer: RTL and testbench



---
 rtl/level_debouncer.sv | 106 ++++++++++
 tb/tb_level_debouncer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/level_debouncer.sv
// Debounces a raw asynchronous level into a clean clock-synchronous level.
// Uses an N-flop synchronizer, a four-state qualify FSM and a saturating glitch counter.
`timescale 1ns/1ps
module level_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int GLITCH_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                level_in,
  output logic                level_out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] s;
  logic                   sync;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign sync = s[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], level_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LOW;
      cnt        <= '0;
      level_out  <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      case (state)
        ST_LOW: begin
          if (sync) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!sync) begin
            state <= ST_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_cnt != '1) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
          end else if (cnt == CNT_LAST) begin
            state     <= ST_HIGH;
            level_out <= 1'b1;
            cnt       <= '0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sync) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (sync) begin
            state <= ST_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_cnt != '1) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
          end else if (cnt == CNT_LAST) begin
            state     <= ST_LOW;
            level_out <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= ST_LOW;
          cnt       <= '0;
          level_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_debouncer.sv
// Bench for level_debouncer: run-length reference model checked every cycle,
// directed boundary cases with literal expectations, then random bouncy input.
`timescale 1ns/1ps
module tb_level_debouncer;

  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic       clk;
  logic       rst;
  logic       level_in;
  logic       level_out_a, busy_a;
  logic [7:0] glitch_a;
  logic       level_out_b, busy_b;
  logic [1:0] glitch_b;

  int vectors = 0;
  int errors  = 0;

  level_debouncer #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .GLITCH_W(8)) dut_a (
    .clk(clk), .rst(rst), .level_in(level_in),
    .level_out(level_out_a), .busy(busy_a), .glitch_cnt(glitch_a)
  );

  level_debouncer #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .GLITCH_W(2)) dut_b (
    .clk(clk), .rst(rst), .level_in(level_in),
    .level_out(level_out_b), .busy(busy_b), .glitch_cnt(glitch_b)
  );

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FSM sees level_in as sampled SYNC edges ago; a new value is
  // accepted after DB consecutive observations, a shorter run is one glitch.
  logic hist[$];
  logic m_level;
  int   m_run;
  int   m_ga;
  int   m_gb;

  always begin
    logic v;
    @(posedge clk);
    if (!rst) begin
      hist = {};
      for (int i = 0; i <= SYNC; i++) hist.push_front(1'b0);
      m_level = 1'b0;
      m_run   = 0;
      m_ga    = 0;
      m_gb    = 0;
    end else begin
      hist.push_front(level_in);
      void'(hist.pop_back());
      v = hist[SYNC];
      if (v != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = v;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0) begin
          if (m_ga < 255) m_ga++;
          if (m_gb < 3) m_gb++;
        end
        m_run = 0;
      end
    end
    #0.5;
    check("level_out", int'(level_out_a), int'(m_level));
    check("busy", int'(busy_a), int'(m_run > 0));
    check("glitch_cnt", int'(glitch_a), m_ga);
    check("level_out_w2", int'(level_out_b), int'(m_level));
    check("glitch_cnt_w2", int'(glitch_b), m_gb);
  end

  // Input changed at the preceding negedge; first posedge here is E0.
  task automatic profile(input logic old_lvl, input logic new_lvl);
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #0.7;
      check("profile_level", int'(level_out_a), int'((k >= 5) ? new_lvl : old_lvl));
      check("profile_busy", int'(busy_a), int'(k >= 2 && k <= 4));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    level_in = 1'b1;
    #0.3;
    check("reset_level", int'(level_out_a), 0);
    check("reset_busy", int'(busy_a), 0);
    check("reset_glitch", int'(glitch_a), 0);
    idle(3);
    rst = 1'b1;
    profile(1'b0, 1'b1);

    idle(10);
    level_in = 1'b0;
    profile(1'b1, 1'b0);
    idle(10);
    check("clean_glitch", int'(glitch_a), 0);

    // One sampled cycle high
    @(negedge clk); level_in = 1'b1;
    @(negedge clk); level_in = 1'b0;
    idle(8);
    check("single_glitch", int'(glitch_a), 1);
    check("single_level", int'(level_out_a), 0);
    // Narrow pulse straddling a rising edge is captured once
    @(negedge clk); #0.9 level_in = 1'b1; #0.2 level_in = 1'b0;
    idle(8);
    check("straddle_glitch", int'(glitch_a), 2);
    // Narrow pulse between edges is never captured
    @(negedge clk); #0.3 level_in = 1'b1; #0.2 level_in = 1'b0;
    idle(8);
    check("uncaptured_glitch", int'(glitch_a), 2);

    @(negedge clk); level_in = 1'b1;
    idle(3);
    level_in = 1'b0;
    idle(8);
    check("pulse3_level", int'(level_out_a), 0);
    check("pulse3_glitch", int'(glitch_a), 3);

    @(negedge clk); level_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #0.7;
      check("pulse4_level", int'(level_out_a), int'(k >= 5));
      if (k == 3) begin
        @(negedge clk);
        level_in = 1'b0;
      end
    end
    idle(10);
    check("pulse4_fall", int'(level_out_a), 0);
    check("pulse4_glitch", int'(glitch_a), 3);

    // Bounce while qualifying a fall
    @(negedge clk); level_in = 1'b1;
    idle(10);
    check("bounce_pre", int'(level_out_a), 1);
    level_in = 1'b0;
    idle(2);
    level_in = 1'b1;
    idle(1);
    level_in = 1'b0;
    idle(5);
    check("bounce_hold", int'(level_out_a), 1);
    idle(5);
    check("bounce_final", int'(level_out_a), 0);
    check("bounce_glitch", int'(glitch_a), 4);

    // Asynchronous reset while WAIT_HIGH is in progress
    @(negedge clk); level_in = 1'b1;
    repeat (3) @(posedge clk);
    #0.5;
    check("pre_reset_busy", int'(busy_a), 1);
    #0.2 rst = 1'b0;
    #0.1;
    check("async_level", int'(level_out_a), 0);
    check("async_busy", int'(busy_a), 0);
    check("async_glitch", int'(glitch_a), 0);
    check("async_glitch_w2", int'(glitch_b), 0);
    level_in = 1'b0;
    idle(2);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk); level_in = 1'b1;
      @(negedge clk); level_in = 1'b0;
      idle(6);
      check("sat_w2", int'(glitch_b), (i + 1 > 3) ? 3 : i + 1);
    end

    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        #($urandom_range(1, 8) * 0.1) level_in = ~level_in;
        #0.2 level_in = ~level_in;
      end else begin
        @(negedge clk);
        level_in = 1'($urandom_range(0, 1));
        idle($urandom_range(0, 6));
      end
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
